cpu_controller: RTL and testbench

Eight-phase instruction sequencer for the VeriRISC-style core. It sits directly upstream of the program counter and drives the counter's `load` (`load_pc`) and `enab` (`inc_pc`) inputs. It also drives the instruction/accumulator register loads, the memory read/write strobes, the address-mux select and the data bus enable. It decodes the 3-bit opcode from the instruction register and the accumulator zero flag.

---
 rtl/cpu_controller.sv | 141 ++++++++++++++
 tb/tb_cpu_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for a VeriRISC-style core.
// Decodes opcode/zero into PC, IR, AC, memory and bus control strobes.
module cpu_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ac,
    output logic       mem_wr,
    output logic       data_e
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t state_r;
    state_t next_s;
    logic   alu_op_s;
    logic   is_hlt_s;
    logic   is_sto_s;
    logic   is_jmp_s;

    // State register; reset overrides every transition, including HALTED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= INST_ADDR;
        end else begin
            state_r <= next_s;
        end
    end

    // Opcode class decode shared by the phase decode below.
    always_comb begin
        alu_op_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
        is_hlt_s = (opcode == OP_HLT);
        is_sto_s = (opcode == OP_STO);
        is_jmp_s = (opcode == OP_JMP);
    end

    // Next-state and combinational output decode from the current phase.
    always_comb begin
        next_s  = state_r;
        sel     = 1'b0;
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ac = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        case (state_r)
            INST_ADDR: begin
                next_s = INST_FETCH;
                sel    = 1'b1;
            end
            INST_FETCH: begin
                next_s = INST_LOAD;
                sel    = 1'b1;
                mem_rd = 1'b1;
            end
            INST_LOAD: begin
                next_s  = IDLE;
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            IDLE: begin
                next_s  = OP_ADDR;
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                // PC still steps past a HLT so a restart resumes after it.
                inc_pc = 1'b1;
                halt   = is_hlt_s;
                if ((HALT_STICKY == 1'b1) && is_hlt_s) begin
                    next_s = HALTED;
                end else begin
                    next_s = OP_FETCH;
                end
            end
            OP_FETCH: begin
                next_s = ALU_OP;
                mem_rd = alu_op_s;
            end
            ALU_OP: begin
                // zero only matters here: a taken SKZ gives the second PC step.
                next_s  = STORE;
                mem_rd  = alu_op_s;
                inc_pc  = (opcode == OP_SKZ) && zero;
                load_pc = is_jmp_s;
                data_e  = is_sto_s;
            end
            STORE: begin
                next_s  = INST_ADDR;
                mem_rd  = alu_op_s;
                load_ac = alu_op_s;
                load_pc = is_jmp_s;
                mem_wr  = is_sto_s;
                data_e  = is_sto_s;
            end
            HALTED: begin
                next_s = HALTED;
                halt   = 1'b1;
            end
            default: begin
                next_s = INST_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller, sticky and non-sticky HLT.
// Output vectors are {sel,mem_rd,load_ir,halt,inc_pc,load_pc,load_ac,mem_wr,data_e}.
module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;

    logic s_sel, s_mem_rd, s_load_ir, s_halt, s_inc_pc, s_load_pc, s_load_ac, s_mem_wr, s_data_e;
    logic n_sel, n_mem_rd, n_load_ir, n_halt, n_inc_pc, n_load_pc, n_load_ac, n_mem_wr, n_data_e;

    int checks;
    int failures;

    cpu_controller #(.HALT_STICKY(1'b1)) dut_sticky (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(s_sel), .mem_rd(s_mem_rd), .load_ir(s_load_ir), .halt(s_halt),
        .inc_pc(s_inc_pc), .load_pc(s_load_pc), .load_ac(s_load_ac),
        .mem_wr(s_mem_wr), .data_e(s_data_e)
    );

    cpu_controller #(.HALT_STICKY(1'b0)) dut_pulse (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(n_sel), .mem_rd(n_mem_rd), .load_ir(n_load_ir), .halt(n_halt),
        .inc_pc(n_inc_pc), .load_pc(n_load_pc), .load_ac(n_load_ac),
        .mem_wr(n_mem_wr), .data_e(n_data_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] sticky_vec();
        return {s_sel, s_mem_rd, s_load_ir, s_halt, s_inc_pc, s_load_pc, s_load_ac, s_mem_wr, s_data_e};
    endfunction

    function automatic logic [8:0] pulse_vec();
        return {n_sel, n_mem_rd, n_load_ir, n_halt, n_inc_pc, n_load_pc, n_load_ac, n_mem_wr, n_data_e};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one 8-cycle instruction starting in INST_ADDR; ends in the next cycle 1.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic [1:8][8:0] exp_s, input logic [1:8][8:0] exp_n);
        for (int c = 1; c <= 8; c++) begin
            opcode = op;
            zero   = (c == 7) ? z : ~z;
            #1;
            check($sformatf("%s_sticky_c%0d", tag, c), sticky_vec(), exp_s[c]);
            check($sformatf("%s_pulse_c%0d", tag, c), pulse_vec(), exp_n[c]);
            tick();
        end
    endtask

    localparam logic [1:8][8:0] EXP_ADD = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000010000, 9'b010000000, 9'b010000000, 9'b010000100};
    localparam logic [1:8][8:0] EXP_STO = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000010000, 9'b000000000, 9'b000000001, 9'b000000011};
    localparam logic [1:8][8:0] EXP_SKZ1 = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000010000, 9'b000000000, 9'b000010000, 9'b000000000};
    localparam logic [1:8][8:0] EXP_SKZ0 = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000010000, 9'b000000000, 9'b000000000, 9'b000000000};
    localparam logic [1:8][8:0] EXP_JMP = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000010000, 9'b000000000, 9'b000001000, 9'b000001000};
    localparam logic [1:8][8:0] EXP_HLT_S = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000110000, 9'b000100000, 9'b000100000, 9'b000100000};
    localparam logic [1:8][8:0] EXP_HLT_N = {
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000110000, 9'b000000000, 9'b000000000, 9'b000000000};

    localparam logic [8:0] RESET_VEC  = 9'b100000000;
    localparam logic [8:0] HALTED_VEC = 9'b000100000;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        opcode   = 3'd2;
        zero     = 1'b0;

        // Reset held: both stay in INST_ADDR.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_hold_sticky", sticky_vec(), RESET_VEC);
            check("reset_hold_pulse", pulse_vec(), RESET_VEC);
        end
        rst = 1'b0;

        run_instr("add", 3'd2, 1'b0, EXP_ADD, EXP_ADD);
        run_instr("sto", 3'd6, 1'b0, EXP_STO, EXP_STO);
        run_instr("skz_z1", 3'd1, 1'b1, EXP_SKZ1, EXP_SKZ1);
        run_instr("skz_z0", 3'd1, 1'b0, EXP_SKZ0, EXP_SKZ0);
        run_instr("jmp", 3'd7, 1'b0, EXP_JMP, EXP_JMP);
        run_instr("lda", 3'd5, 1'b0, EXP_ADD, EXP_ADD);

        // Reset mid-instruction while in OP_FETCH.
        opcode = 3'd2;
        zero   = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("midrst_sticky_c%0d", c), sticky_vec(), EXP_ADD[c]);
            if (c < 6) begin
                tick();
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_after_sticky", sticky_vec(), RESET_VEC);
        check("midrst_after_pulse", pulse_vec(), RESET_VEC);

        run_instr("add_after_rst", 3'd2, 1'b0, EXP_ADD, EXP_ADD);

        // HLT: sticky parks, non-sticky pulses and wraps.
        run_instr("hlt", 3'd0, 1'b0, EXP_HLT_S, EXP_HLT_N);
        check("hlt_wrap_pulse", pulse_vec(), RESET_VEC);
        for (int i = 0; i < 20; i++) begin
            opcode = 3'($urandom_range(7, 0));
            zero   = 1'($urandom_range(1, 0));
            #1;
            check($sformatf("halted_hold_%0d", i), sticky_vec(), HALTED_VEC);
            tick();
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_rst_sticky", sticky_vec(), RESET_VEC);
        check("halt_rst_pulse", pulse_vec(), RESET_VEC);

        run_instr("xor_after_halt", 3'd4, 1'b1, EXP_ADD, EXP_ADD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
